router_ingress: RTL and testbench



---
 rtl/router_pkg.sv | 27 ++
 rtl/router_ingress_fsm.sv | 100 ++++++++++
 rtl/router_ingress.sv | 132 +++++++++++++
 tb/tb_router_ingress.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : router_pkg                                              |
// | Brief    : Shared types and header field positions for the router. |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
package router_pkg;

  localparam int ADDR_W   = 2;
  localparam int LEN_MSB  = 7;
  localparam int LEN_LSB  = 2;
  localparam int ADDR_MSB = 1;
  localparam int ADDR_LSB = 0;

  localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'b11;

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    WAIT_EMPTY   = 3'd1,
    LOAD_FIRST   = 3'd2,
    LOAD_DATA    = 3'd3,
    LOAD_PARITY  = 3'd4,
    CHECK_PARITY = 3'd5
  } state_t;

endpackage
`default_nettype wire

// File: rtl/router_ingress_fsm.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : router_ingress_fsm                                      |
// | Brief    : Packet sequencing FSM; decodes busy, lfd_state, fifo_wr. |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
module router_ingress_fsm
  import router_pkg::*;
#(
  parameter int NUM_PORTS = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pkt_valid,
  input  logic [ADDR_W-1:0]    hdr_addr,
  input  logic [ADDR_W-1:0]    dest,
  input  logic [NUM_PORTS-1:0] fifo_full,
  input  logic [NUM_PORTS-1:0] fifo_empty,
  input  logic [NUM_PORTS-1:0] soft_rst,
  output state_t               state,
  output logic                 busy,
  output logic                 lfd_state,
  output logic [NUM_PORTS-1:0] fifo_wr,
  output logic                 dest_full,
  output logic                 dest_srst
);

  state_t r_state;
  state_t w_next;
  logic   w_hdr_empty;
  logic   w_dest_empty;

  // In IDLE the destination register is not loaded yet, so the empty
  // check for the incoming header looks at the header's own address.
  always_comb begin
    w_hdr_empty  = 1'b0;
    w_dest_empty = 1'b0;
    dest_full    = 1'b0;
    dest_srst    = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (hdr_addr == ADDR_W'(i)) begin
        w_hdr_empty = fifo_empty[i];
      end
      if (dest == ADDR_W'(i)) begin
        w_dest_empty = fifo_empty[i];
        dest_full    = fifo_full[i];
        dest_srst    = soft_rst[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (pkt_valid && (hdr_addr != ADDR_INVALID)) begin
          w_next = w_hdr_empty ? LOAD_FIRST : WAIT_EMPTY;
        end
      end
      WAIT_EMPTY:   if (w_dest_empty) w_next = LOAD_FIRST;
      LOAD_FIRST:   w_next = LOAD_DATA;
      LOAD_DATA:    if (!dest_full && !pkt_valid) w_next = LOAD_PARITY;
      LOAD_PARITY:  if (!dest_full) w_next = CHECK_PARITY;
      CHECK_PARITY: w_next = IDLE;
      default:      w_next = IDLE;
    endcase
    if ((r_state != IDLE) && dest_srst) begin
      w_next = IDLE;
    end
  end

  always_comb begin
    busy      = 1'b1;
    lfd_state = 1'b0;
    fifo_wr   = '0;
    case (r_state)
      IDLE:       busy = 1'b0;
      LOAD_FIRST: lfd_state = 1'b1;
      LOAD_DATA:  busy = dest_full;
      default:    busy = 1'b1;
    endcase
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (((r_state == LOAD_DATA) || (r_state == LOAD_PARITY)) && (dest == ADDR_W'(i))) begin
        fifo_wr[i] = 1'b1;
      end
    end
  end

  assign state = r_state;

endmodule
`default_nettype wire

// File: rtl/router_ingress.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : router_ingress                                          |
// | Brief    : Byte-serial packet ingress with parity check.           |
// |            ROUTER_INGRESS_LEN_CHECK_EN adds payload length check.  |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
module router_ingress
  import router_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int NUM_PORTS = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pkt_valid,
  input  logic [DATA_W-1:0]    data_in,
  input  logic [NUM_PORTS-1:0] fifo_full,
  input  logic [NUM_PORTS-1:0] fifo_empty,
  input  logic [NUM_PORTS-1:0] soft_rst,
  output logic [DATA_W-1:0]    d_out,
  output logic [NUM_PORTS-1:0] fifo_wr,
  output logic                 lfd_state,
  output logic                 busy,
  output logic                 parity_done,
  output logic                 err
);

  state_t              w_state;
  logic                w_dest_full;
  logic                w_dest_srst;
  logic                w_hdr_acc;
  logic                w_pay_acc;
  logic                w_mismatch;
  logic [DATA_W-1:0]   r_d_out;
  logic [DATA_W-1:0]   r_hdr;
  logic [ADDR_W-1:0]   r_dest;
  logic [DATA_W-1:0]   r_calc_par;
  logic [DATA_W-1:0]   r_rx_par;
  logic                r_parity_done;
  logic                r_err;

  router_ingress_fsm #(
    .NUM_PORTS (NUM_PORTS)
  ) u_fsm (
    .clk        (clk),
    .rst        (rst),
    .pkt_valid  (pkt_valid),
    .hdr_addr   (data_in[ADDR_MSB:ADDR_LSB]),
    .dest       (r_dest),
    .fifo_full  (fifo_full),
    .fifo_empty (fifo_empty),
    .soft_rst   (soft_rst),
    .state      (w_state),
    .busy       (busy),
    .lfd_state  (lfd_state),
    .fifo_wr    (fifo_wr),
    .dest_full  (w_dest_full),
    .dest_srst  (w_dest_srst)
  );

  assign w_hdr_acc = (w_state == IDLE) && pkt_valid &&
                     (data_in[ADDR_MSB:ADDR_LSB] != ADDR_INVALID);
  assign w_pay_acc = (w_state == LOAD_DATA) && !w_dest_full && pkt_valid;

`ifdef ROUTER_INGRESS_LEN_CHECK_EN
  logic [LEN_MSB-LEN_LSB:0] r_len_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_len_cnt <= '0;
    end else if (w_hdr_acc) begin
      r_len_cnt <= '0;
    end else if (w_pay_acc) begin
      r_len_cnt <= r_len_cnt + 1'b1;
    end
  end

  assign w_mismatch = (r_calc_par != r_rx_par) || (r_len_cnt != r_hdr[LEN_MSB:LEN_LSB]);
`else
  assign w_mismatch = (r_calc_par != r_rx_par);
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_d_out       <= '0;
      r_hdr         <= '0;
      r_dest        <= '0;
      r_calc_par    <= '0;
      r_rx_par      <= '0;
      r_parity_done <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_parity_done <= 1'b0;
      case (w_state)
        IDLE: begin
          if (w_hdr_acc) begin
            r_hdr      <= data_in;
            r_dest     <= data_in[ADDR_MSB:ADDR_LSB];
            r_calc_par <= data_in;
            r_err      <= 1'b0;
          end
        end
        LOAD_FIRST: r_d_out <= r_hdr;
        LOAD_DATA: begin
          // A full destination freezes the whole datapath so the held byte is written later.
          if (!w_dest_full) begin
            r_d_out <= data_in;
            if (pkt_valid) begin
              r_calc_par <= r_calc_par ^ data_in;
            end else begin
              r_rx_par <= data_in;
            end
          end
        end
        CHECK_PARITY: begin
          if (!w_dest_srst) begin
            r_err         <= w_mismatch;
            r_parity_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign d_out       = r_d_out;
  assign parity_done = r_parity_done;
  assign err         = r_err;

endmodule
`default_nettype wire

// File: tb/tb_router_ingress.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : tb_router_ingress                                       |
// | Brief    : Directed self-checking bench with write/err scoreboard. |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
module tb_router_ingress;

`ifdef ROUTER_INGRESS_LEN_CHECK_EN
  localparam bit LEN_ON = 1'b1;
`else
  localparam bit LEN_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       pkt_valid;
  logic [7:0] data_in;
  logic [2:0] fifo_full;
  logic [2:0] fifo_empty;
  logic [2:0] soft_rst;
  logic [7:0] d_out;
  logic [2:0] fifo_wr;
  logic       lfd_state;
  logic       busy;
  logic       parity_done;
  logic       err;

  int n_checks = 0;
  int n_errors = 0;

  // Expected FIFO writes as {one-hot port, byte}, and expected err per completed packet.
  logic [10:0] exp_q[$];
  logic        err_q[$];
  logic [10:0] e_wr;
  logic        e_err;

  router_ingress #(
    .DATA_W    (8),
    .NUM_PORTS (3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pkt_valid   (pkt_valid),
    .data_in     (data_in),
    .fifo_full   (fifo_full),
    .fifo_empty  (fifo_empty),
    .soft_rst    (soft_rst),
    .d_out       (d_out),
    .fifo_wr     (fifo_wr),
    .lfd_state   (lfd_state),
    .busy        (busy),
    .parity_done (parity_done),
    .err         (err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      exp_q.delete();
      err_q.delete();
    end else begin
      if ((fifo_wr != 3'b000) && ((fifo_wr & fifo_full) == 3'b000)) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", {21'd0, fifo_wr, d_out}, 32'h7FF);
        end else begin
          e_wr = exp_q.pop_front();
          chk("fifo_write", {21'd0, fifo_wr, d_out}, {21'd0, e_wr});
        end
      end
      if (soft_rst != 3'b000) exp_q.delete();
      if (parity_done) begin
        if (err_q.size() == 0) begin
          chk("unexpected_parity_done", {31'd0, parity_done}, 32'd0);
        end else begin
          e_err = err_q.pop_front();
          chk("err_at_done", {31'd0, err}, {31'd0, e_err});
        end
      end
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present a byte and hold it until a cycle with busy low consumes it.
  task automatic drive_byte(input logic v, input logic [7:0] b);
    int t;
    pkt_valid = v;
    data_in   = b;
    t = 0;
    @(negedge clk);
    while (busy && t < 50) begin
      t++;
      @(negedge clk);
    end
    chk("drive_accept_busy", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic send_pkt(input logic [7:0] hdr, input logic [63:0] pl, input int n,
                          input logic [7:0] par, input int abort_n);
    logic [7:0] x;
    logic [2:0] oh;
    logic       e;
    int         nb;
    oh = 3'b000;
    if (hdr[1:0] != 2'b11) begin
      oh = 3'b001 << hdr[1:0];
      x  = hdr;
      exp_q.push_back({oh, hdr});
      for (int i = 0; i < n; i++) begin
        exp_q.push_back({oh, pl[8*i +: 8]});
        x = x ^ pl[8*i +: 8];
      end
      exp_q.push_back({oh, par});
      e = (x != par) || (LEN_ON && (n != int'(hdr[7:2])));
      if (abort_n < 0) err_q.push_back(e);
    end
    drive_byte(1'b1, hdr);
    if (hdr[1:0] != 2'b11) begin
      nb = (abort_n < 0) ? n : abort_n;
      for (int i = 0; i < nb; i++) drive_byte(1'b1, pl[8*i +: 8]);
      if (abort_n < 0) begin
        drive_byte(1'b0, par);
      end else begin
        data_in  = pl[8*abort_n +: 8];
        soft_rst = oh;
        @(posedge clk);
        #1;
        soft_rst  = 3'b000;
        pkt_valid = 1'b0;
        @(negedge clk);
        chk("srst_fifo_wr", {29'd0, fifo_wr}, 32'd0);
        chk("srst_busy", {31'd0, busy}, 32'd0);
      end
    end
    pkt_valid = 1'b0;
    data_in   = 8'h00;
  endtask

  task automatic wait_lfd();
    int t;
    t = 0;
    @(negedge clk);
    while (!lfd_state && t < 20) begin
      t++;
      @(negedge clk);
    end
    chk("lfd_seen", {31'd0, lfd_state}, 32'd1);
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (!parity_done && t < 30) begin
      t++;
      @(negedge clk);
    end
    chk("parity_done_seen", {31'd0, parity_done}, 32'd1);
  endtask

  logic [7:0] ev [5];

  initial begin
    rst        = 1'b0;
    pkt_valid  = 1'b0;
    data_in    = 8'h00;
    fifo_full  = 3'b000;
    fifo_empty = 3'b111;
    soft_rst   = 3'b000;
    ev = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D};

    idle(3);
    @(negedge clk);
    chk("rst_d_out", {24'd0, d_out}, 32'd0);
    chk("rst_fifo_wr", {29'd0, fifo_wr}, 32'd0);
    chk("rst_lfd", {31'd0, lfd_state}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_parity_done", {31'd0, parity_done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    idle(2);

    // Good-parity packet to port 1: five back-to-back writes.
    fork
      send_pkt(8'h0D, 64'h332211, 3, 8'h0D, -1);
      begin
        wait_lfd();
        chk("t1_lfd_no_wr", {29'd0, fifo_wr}, 32'd0);
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          chk("t1_wr_en", {29'd0, fifo_wr}, 32'h2);
          chk("t1_wr_data", {24'd0, d_out}, {24'd0, ev[i]});
        end
        @(negedge clk);
        chk("t1_wr_end", {29'd0, fifo_wr}, 32'd0);
        wait_done();
        chk("t1_err", {31'd0, err}, 32'd0);
      end
    join
    idle(3);

    // Bad parity byte.
    fork
      send_pkt(8'h0D, 64'h332211, 3, 8'hFF, -1);
      begin
        @(negedge clk);
        wait_done();
        chk("t2_err", {31'd0, err}, 32'd1);
      end
    join
    idle(3);

    // Full stall after the second write; err clears with this header.
    fork
      send_pkt(8'h0D, 64'h332211, 3, 8'h0D, -1);
      begin
        wait_lfd();
        chk("t3_err_cleared", {31'd0, err}, 32'd0);
        @(negedge clk);
        chk("t3_first_wr", {29'd0, fifo_wr}, 32'h2);
        @(negedge clk);
        chk("t3_busy_pre", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
        fifo_full[1] = 1'b1;
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          chk("t3_busy_full", {31'd0, busy}, 32'd1);
          chk("t3_hold", {24'd0, d_out}, 32'h22);
        end
        @(posedge clk);
        #1;
        fifo_full[1] = 1'b0;
        @(negedge clk);
        chk("t3_busy_post", {31'd0, busy}, 32'd0);
        chk("t3_resume_data", {24'd0, d_out}, 32'h22);
        chk("t3_resume_wr", {29'd0, fifo_wr}, 32'h2);
      end
    join
    idle(3);

    // Length-0 packet to port 2 whose FIFO is not empty for 4 cycles.
    fifo_empty[2] = 1'b0;
    fork
      send_pkt(8'h02, 64'h0, 0, 8'h02, -1);
      begin
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          chk("t4_wait_busy", {31'd0, busy}, 32'd1);
          chk("t4_wait_lfd", {31'd0, lfd_state}, 32'd0);
          chk("t4_wait_wr", {29'd0, fifo_wr}, 32'd0);
        end
        @(posedge clk);
        #1;
        fifo_empty[2] = 1'b1;
        @(negedge clk);
        chk("t4_last_wait", {31'd0, lfd_state}, 32'd0);
        @(negedge clk);
        chk("t4_lfd", {31'd0, lfd_state}, 32'd1);
      end
    join
    idle(3);

    // Invalid address 3 is dropped.
    fork
      send_pkt(8'h07, 64'h0, 0, 8'h00, -1);
      begin
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          chk("t5_busy", {31'd0, busy}, 32'd0);
          chk("t5_wr", {29'd0, fifo_wr}, 32'd0);
          chk("t5_lfd", {31'd0, lfd_state}, 32'd0);
        end
      end
    join
    idle(2);

    // Soft reset mid-payload, then a normal packet to port 0.
    send_pkt(8'h0D, 64'h332211, 3, 8'h0D, 2);
    idle(2);
    fork
      send_pkt(8'h04, 64'hAA, 1, 8'hAE, -1);
      begin
        wait_lfd();
        wait_done();
        chk("t6_err", {31'd0, err}, 32'd0);
      end
    join
    idle(3);

    // Header claims 3 payload bytes but only 2 follow; parity is correct.
    fork
      send_pkt(8'h0C, 64'h0201, 2, 8'h0F, -1);
      begin
        @(negedge clk);
        wait_done();
        chk("t7_len_err", {31'd0, err}, {31'd0, LEN_ON});
      end
    join
    idle(3);

    // Reset in the header write cycle.
    pkt_valid = 1'b1;
    data_in   = 8'h0D;
    idle(1);
    data_in = 8'h11;
    idle(1);
    rst = 1'b0;
    @(negedge clk);
    chk("t8_pre_rst_wr", {29'd0, fifo_wr}, 32'h2);
    @(posedge clk);
    #1;
    rst       = 1'b1;
    pkt_valid = 1'b0;
    @(negedge clk);
    chk("t8_d_out", {24'd0, d_out}, 32'd0);
    chk("t8_fifo_wr", {29'd0, fifo_wr}, 32'd0);
    chk("t8_busy", {31'd0, busy}, 32'd0);
    chk("t8_lfd", {31'd0, lfd_state}, 32'd0);
    chk("t8_parity_done", {31'd0, parity_done}, 32'd0);
    chk("t8_err", {31'd0, err}, 32'd0);
    idle(3);

    chk("writes_drained", exp_q.size(), 32'd0);
    chk("errs_drained", err_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
